elevator_call_scheduler: RTL and testbench
==========================================

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 16, door-open hold time in clk cycles (legal 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 call_btn  input  4  raw floor call buttons, bit i = floor i, asynchronous to clk, level-high while pressed.
REQ-005 present_floor  input  4  one-hot current car floor, returned by the floor controller (0001=floor 0 .. 1000=floor 3).
REQ-006 requested_floor  output  4  one-hot floor command to the floor controller, registered.
REQ-007 pending  output  4  latched outstanding calls, registered.
REQ-008 door_open  output  1  high while in DWELL.
REQ-009 dir_up  output  1  high in MOVE_UP; dir_dn  output  1  high in MOVE_DOWN.
REQ-010 err_floor  output  1  registered, high in any cycle following a sampled non-one-hot present_floor.

Function
REQ-011 call_btn SHALL pass a 2-flop synchronizer plus a previous-value flop; a rising edge on the synchronized value sets pending[i].
REQ-012 Latency: call_btn[i] first sampled high at edge k -> pending[i]=1 after edge k+2; a held button sets pending once only.
REQ-013 States: IDLE, MOVE_UP, MOVE_DOWN, DWELL; encoding free.
REQ-014 "Above"/"below" SHALL mean pending bits at indices strictly greater/less than the one-hot index of present_floor; "nearest" = closest such index.
REQ-015 IDLE: pending at present floor -> DWELL; else any above -> MOVE_UP; else any below -> MOVE_DOWN; else stay; requested_floor=present_floor.
REQ-016 MOVE_UP: requested_floor = nearest pending above, recomputed every cycle so newly latched intermediate calls are served first; pending at present floor -> DWELL; no pending above and none at present -> IDLE.
REQ-017 MOVE_DOWN: symmetric to REQ-016 with "below".
REQ-018 DWELL entry: clear pending bit of present floor, load dwell counter to DWELL_CYCLES-1, requested_floor=present_floor, door_open=1.
REQ-019 DWELL: counter decrements each cycle; at 0 exit: pending in prior direction -> same MOVE state; else pending in opposite direction -> opposite MOVE; else IDLE.
REQ-020 DWELL entered from IDLE SHALL treat prior direction as up.
REQ-021 A new edge for the floor currently in DWELL SHALL leave pending clear and reload the counter to DWELL_CYCLES-1.
REQ-022 Set of pending[i] and clear of pending[j], i!=j, same cycle: both take effect.
REQ-023 Non-one-hot present_floor (incl. 0000): state, counter, requested_floor frozen; pending still accepts new calls; err_floor=1 next cycle; resumes when one-hot returns.
REQ-024 Arrival SHALL be detected only from present_floor, never from requested_floor.

Reset
REQ-025 rst_n low at a clk edge: state=IDLE, requested_floor=0001, pending=0000, door_open=0, dir_up=0, dir_dn=0, err_floor=0, counter=0, synchronizer flops=0.
REQ-026 Reset mid-move or mid-dwell SHALL discard all pending calls; a button held through reset release sets pending per REQ-012 edge rule (synchronizer starts at 0, so it registers as a new edge).

Verification (DWELL_CYCLES=4)
REQ-027 Reset, present_floor=0001, pulse call_btn=1000 -> pending=1000 after edge k+2, dir_up=1, requested_floor=1000.
REQ-028 From REQ-027 drive present_floor 0010 then, while moving, press 0100 -> requested_floor switches to 0100; at present_floor=0100 door_open=1 exactly 4 cycles, pending=1000, then MOVE_UP resumes with requested_floor=1000.
REQ-029 Car at 1000 in DWELL, pending=0011 -> exit to MOVE_DOWN, requested_floor=0010, then 0001 after floor 1 dwell.
REQ-030 In DWELL at floor 2, re-press call_btn=0100 -> pending bit stays 0, door_open held 4 cycles from the re-press edge detection.
REQ-031 present_floor=0110 for 3 cycles while MOVE_UP -> err_floor=1, requested_floor unchanged, a press on floor 0 still sets pending[0]; restore 0010 -> err_floor=0, operation resumes.
REQ-032 Assert rst_n=0 for one edge mid-dwell with pending=1001 -> all outputs match REQ-025 after that edge.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Purpose: latches floor call buttons and steers a four-floor car. It sends
// one-hot floor commands to a floor controller and watches the returned
// present_floor to detect arrival. When the car reaches a floor with a
// pending call, the scheduler holds the door open for DWELL_CYCLES cycles.
//
// Parameters:
//   DWELL_CYCLES    door-open hold time in clk cycles (1..255)
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           synchronous active-low reset
//   call_btn[3:0]   raw call buttons, asynchronous, level-high while pressed
//   present_floor   one-hot car position from the floor controller
//   requested_floor one-hot floor command (registered)
//   pending[3:0]    latched outstanding calls (registered)
//   door_open       high while dwelling at a floor
//   dir_up, dir_dn  high while moving up / down
//   err_floor       registered, high after a sampled non-one-hot present_floor
//   state_dbg       current FSM state, for observation only
//
// Handshake: this block has no valid/ready channel. A call is accepted when
// the synchronized button shows a rising edge. present_floor is the only
// arrival indication, and the block trusts it whenever it is one-hot.
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int DWELL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_btn,
  input  logic [3:0] present_floor,
  output logic [3:0] requested_floor,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       dir_up,
  output logic       dir_dn,
  output logic       err_floor,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DWELL     = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] req_nx, pend_nx, clr;
  logic       prior_up, prior_up_nx;

  logic [3:0] sync1, sync2, prev, rise;
  logic       floor_valid, at_floor;
  logic [3:0] below_mask, above_bits, below_bits, near_up, near_dn;

  // Highest set bit of a 4-bit vector, returned as one-hot (or zero).
  function automatic logic [3:0] highest_bit(input logic [3:0] v);
    highest_bit = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        highest_bit    = '0;
        highest_bit[i] = 1'b1;
      end
    end
  endfunction

  // Two-flop synchronizer plus a previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= call_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // For a one-hot floor value f, f-1 covers every index below it.
  assign floor_valid = $onehot(present_floor);
  assign below_mask  = present_floor - 4'd1;
  assign above_bits  = pending & ~(present_floor | below_mask);
  assign below_bits  = pending & below_mask;
  assign near_up     = above_bits & (~above_bits + 4'd1);
  assign near_dn     = highest_bit(below_bits);
  assign at_floor    = |(pending & present_floor);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    req_nx      = requested_floor;
    prior_up_nx = prior_up;
    clr         = '0;

    // An invalid floor reading freezes the FSM. Calls are still latched.
    if (floor_valid) begin
      case (state)
        IDLE, MOVE_UP, MOVE_DOWN: begin
          if (at_floor) begin
            state_nx    = DWELL;
            cnt_nx      = DWELL_LOAD;
            req_nx      = present_floor;
            clr         = present_floor;
            prior_up_nx = (state != MOVE_DOWN);
          end else if (state != MOVE_DOWN && |above_bits) begin
            state_nx = MOVE_UP;
            req_nx   = near_up;
          end else if (state != MOVE_UP && |below_bits) begin
            state_nx = MOVE_DOWN;
            req_nx   = near_dn;
          end else begin
            state_nx = IDLE;
            req_nx   = present_floor;
          end
        end
        DWELL: begin
          // A fresh call at the open floor is absorbed and restarts the hold.
          clr = present_floor;
          if (|(rise & present_floor)) begin
            cnt_nx = DWELL_LOAD;
          end else if (cnt != 8'd0) begin
            cnt_nx = cnt - 8'd1;
          end else if (prior_up && |above_bits) begin
            state_nx = MOVE_UP;
            req_nx   = near_up;
          end else if (!prior_up && |below_bits) begin
            state_nx = MOVE_DOWN;
            req_nx   = near_dn;
          end else if (|above_bits) begin
            state_nx = MOVE_UP;
            req_nx   = near_up;
          end else if (|below_bits) begin
            state_nx = MOVE_DOWN;
            req_nx   = near_dn;
          end else begin
            state_nx = IDLE;
            req_nx   = present_floor;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    pend_nx = (pending | rise) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      requested_floor <= 4'b0001;
      pending         <= '0;
      prior_up        <= 1'b1;
      err_floor       <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      requested_floor <= req_nx;
      pending         <= pend_nx;
      prior_up        <= prior_up_nx;
      err_floor       <= ~floor_valid;
    end
  end

  assign door_open = (state == DWELL);
  assign dir_up    = (state == MOVE_UP);
  assign dir_dn    = (state == MOVE_DOWN);
  assign state_dbg = state;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_scheduler
//
// Testbench for elevator_call_scheduler with DWELL_CYCLES = 4. It plays the
// floor controller: the car walks toward requested_floor with random travel
// times. Random presses, glitches on present_floor and resets are mixed in.
// A floor-index reference model predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_elevator_call_scheduler;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] call_btn;
  logic [3:0] present_floor;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       door_open, dir_up, dir_dn, err_floor;
  logic [1:0] state_dbg;

  elevator_call_scheduler #(.DWELL_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .call_btn       (call_btn),
    .present_floor  (present_floor),
    .requested_floor(requested_floor),
    .pending        (pending),
    .door_open      (door_open),
    .dir_up         (dir_up),
    .dir_dn         (dir_dn),
    .err_floor      (err_floor),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DWELL} mode_t;
  mode_t      m_mode;
  int         m_req;        // floor index of the command
  logic [3:0] m_pend;
  logic       m_err;
  int         m_cnt;
  bit         m_up;
  logic [3:0] hist [3];     // button samples from the last three edges

  function automatic int near_above(input logic [3:0] v, input int p);
    for (int i = p + 1; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int near_below(input logic [3:0] v, input int p);
    for (int i = p - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int floor_index(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_req = 0; m_pend = '0; m_err = 1'b0; m_cnt = 0; m_up = 1'b1;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] btn, input logic [3:0] pf);
    logic [3:0] ev, np;
    int p, up_i, dn_i;
    bit go_dwell, dwell_up;
    if (!rst) begin
      model_reset();
      return;
    end
    // Rising edges reach pending two edges after the button is first sampled.
    ev = hist[1] & ~hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn;
    if (!$onehot(pf)) begin
      m_pend = m_pend | ev;
      m_err  = 1'b1;
      return;
    end
    m_err = 1'b0;
    p = floor_index(pf);
    up_i = near_above(m_pend, p);
    dn_i = near_below(m_pend, p);
    np = m_pend | ev;
    go_dwell = 1'b0; dwell_up = 1'b1;
    case (m_mode)
      M_IDLE: begin
        if (m_pend[p]) go_dwell = 1'b1;
        else if (up_i >= 0) begin m_mode = M_UP; m_req = up_i; end
        else if (dn_i >= 0) begin m_mode = M_DOWN; m_req = dn_i; end
        else m_req = p;
      end
      M_UP: begin
        if (m_pend[p]) go_dwell = 1'b1;
        else if (up_i >= 0) m_req = up_i;
        else begin m_mode = M_IDLE; m_req = p; end
      end
      M_DOWN: begin
        if (m_pend[p]) begin go_dwell = 1'b1; dwell_up = 1'b0; end
        else if (dn_i >= 0) m_req = dn_i;
        else begin m_mode = M_IDLE; m_req = p; end
      end
      default: begin
        np[p] = 1'b0;
        if (ev[p]) m_cnt = D - 1;
        else if (m_cnt > 0) m_cnt--;
        else if (m_up && up_i >= 0) begin m_mode = M_UP; m_req = up_i; end
        else if (!m_up && dn_i >= 0) begin m_mode = M_DOWN; m_req = dn_i; end
        else if (up_i >= 0) begin m_mode = M_UP; m_req = up_i; end
        else if (dn_i >= 0) begin m_mode = M_DOWN; m_req = dn_i; end
        else begin m_mode = M_IDLE; m_req = p; end
      end
    endcase
    if (go_dwell) begin
      m_mode = M_DWELL; m_cnt = D - 1; m_req = p; m_up = dwell_up; np[p] = 1'b0;
    end
    m_pend = np;
  endtask

  task automatic compare_all();
    logic [3:0] exp_req;
    exp_req = '0;
    exp_req[m_req] = 1'b1;
    check("requested_floor", 32'(requested_floor), 32'(exp_req));
    check("pending",         32'(pending),         32'(m_pend));
    check("door_open",       32'(door_open),       32'(m_mode == M_DWELL));
    check("dir_up",          32'(dir_up),          32'(m_mode == M_UP));
    check("dir_dn",          32'(dir_dn),          32'(m_mode == M_DOWN));
    check("err_floor",       32'(err_floor),       32'(m_err));
  endtask

  // One clock: the model sees the same inputs the DUT samples, then outputs
  // are compared 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst_n, call_btn, present_floor);
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  int car;
  int move_timer;
  int glitch_left;
  logic [3:0] glitch_val;
  logic [3:0] bad_floor [5];

  initial begin
    bad_floor[0] = 4'b0000; bad_floor[1] = 4'b0110; bad_floor[2] = 4'b0011;
    bad_floor[3] = 4'b1111; bad_floor[4] = 4'b1010;
    model_reset();
    rst_n = 1'b0; call_btn = '0; present_floor = 4'b0001;
    car = 0; move_timer = 3; glitch_left = 0; glitch_val = '0;

    // Reset values against fixed constants.
    tick(); tick();
    check("rst_requested_floor", 32'(requested_floor), 32'h1);
    check("rst_pending",         32'(pending),         32'h0);
    check("rst_door_open",       32'(door_open),       32'h0);
    check("rst_dir_up",          32'(dir_up),          32'h0);
    check("rst_dir_dn",          32'(dir_dn),          32'h0);
    check("rst_err_floor",       32'(err_floor),       32'h0);

    // Single-cycle press of floor 3: pending after edge k+2, then moving up.
    rst_n = 1'b1;
    tick();
    call_btn = 4'b1000;
    tick();                       // edge k
    call_btn = 4'b0000;
    tick();                       // edge k+1
    check("lat_pending_k1", 32'(pending), 32'h0);
    tick();                       // edge k+2
    check("lat_pending_k2", 32'(pending), 32'h8);
    tick();                       // edge k+3
    check("lat_dir_up", 32'(dir_up), 32'h1);
    check("lat_req",    32'(requested_floor), 32'h8);

    // Random operation with the bench acting as the floor controller.
    for (int cyc = 0; cyc < 15000; cyc++) begin
      rst_n = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 15) == 0)
        call_btn[$urandom_range(0, 3)] = ~call_btn[$urandom_range(0, 3)];
      if (move_timer > 0) move_timer--;
      else if ($onehot(requested_floor) && floor_index(requested_floor) != car) begin
        car = (floor_index(requested_floor) > car) ? car + 1 : car - 1;
        move_timer = $urandom_range(2, 6);
      end
      if (glitch_left == 0 && $urandom_range(0, 299) == 0) begin
        glitch_left = $urandom_range(1, 4);
        glitch_val  = bad_floor[$urandom_range(0, 4)];
      end
      if (glitch_left > 0) begin
        present_floor = glitch_val;
        glitch_left--;
      end else begin
        present_floor = '0;
        present_floor[car] = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
